// File: rtl/gemm_top.sv
// Square-matrix multiplier: A and B arrive over AXI-Stream, C = A*B leaves over AXI-Stream.
// An AXI-Lite register block sets the size and sequences load/compute/output.
module gemm_top #(
  parameter int MAX_N = 8
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic [3:0]  S_AXIS_TSTRB,
  input  logic        S_AXIS_TLAST,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic [3:0]  M_AXIS_TSTRB,
  output logic        M_AXIS_TLAST,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY
);

  localparam int AW = $clog2(MAX_N * MAX_N);
  localparam int IW = $clog2(MAX_N * MAX_N + 1);
  localparam logic [3:0] MAX_N4 = 4'(MAX_N);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic        ready_en, bvalid, rvalid;
  logic [31:0] rdata, mode, reg_rd;
  logic [3:0]  size, size_wr;
  logic        wr_hs, rd_hs;
  logic        unused_bits;

  logic [31:0] a_mem [MAX_N*MAX_N];
  logic [31:0] b_mem [MAX_N*MAX_N];
  logic [31:0] c_mem [MAX_N*MAX_N];

  logic [IW-1:0] n_eff, n_m1, nn;
  logic [IW-1:0] ld_idx, out_idx, ci, cj, ck;
  logic [IW-1:0] a_addr, b_addr, c_addr;
  logic [31:0]   acc, prod, mac_sum;
  logic          load_fire, load_last, calc_last, out_fire, out_last;

  assign unused_bits = ^{S_AXI_AWADDR[31:4], S_AXI_AWADDR[1:0], S_AXI_ARADDR[31:4],
                         S_AXI_ARADDR[1:0], S_AXI_WSTRB, S_AXIS_TSTRB, S_AXIS_TLAST};

  // The ready_en flag keeps the address/data readies low until the first edge after reset.
  assign S_AXI_AWREADY = ready_en & ~bvalid;
  assign S_AXI_WREADY  = ready_en & ~bvalid;
  assign S_AXI_ARREADY = ready_en & ~rvalid;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;
  assign M_AXIS_TSTRB  = 4'hF;

  assign wr_hs   = S_AXI_AWVALID & S_AXI_WVALID & S_AXI_AWREADY;
  assign rd_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
  assign size_wr = S_AXI_WDATA[3:0];

  always_comb begin
    reg_rd = '0;
    case (S_AXI_ARADDR[3:2])
      2'd0:    reg_rd = mode;
      2'd1:    reg_rd = {28'd0, size};
      2'd2:    reg_rd = {28'd0, state, (state != IDLE)};
      default: reg_rd = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ready_en <= 1'b0;
      bvalid   <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      mode     <= '0;
      size     <= MAX_N4;
    end else begin
      ready_en <= 1'b1;
      if (wr_hs)             bvalid <= 1'b1;
      else if (S_AXI_BREADY) bvalid <= 1'b0;
      // Configuration only changes while idle; busy-time writes are still acknowledged.
      if (wr_hs && state == IDLE) begin
        if (S_AXI_AWADDR[3:2] == 2'd0) mode <= S_AXI_WDATA;
        if (S_AXI_AWADDR[3:2] == 2'd1)
          size <= (size_wr == 4'd0 || size_wr > MAX_N4) ? MAX_N4 : size_wr;
      end
      if (rd_hs) begin
        rvalid <= 1'b1;
        rdata  <= reg_rd;
      end else if (S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign n_eff   = IW'(size);
  assign n_m1    = n_eff - 1'b1;
  assign nn      = n_eff * n_eff;
  assign a_addr  = ci * n_eff + ck;
  assign b_addr  = ck * n_eff + cj;
  assign c_addr  = ci * n_eff + cj;
  assign prod    = a_mem[a_addr[AW-1:0]] * b_mem[b_addr[AW-1:0]];
  assign mac_sum = ((ck == '0) ? 32'd0 : acc) + prod;

  assign load_fire = S_AXIS_TREADY & S_AXIS_TVALID;
  assign load_last = load_fire && (ld_idx == nn - 1'b1);
  assign calc_last = (state == CALC) && (ck == n_m1) && (cj == n_m1) && (ci == n_m1);
  assign out_fire  = (state == OUT) && M_AXIS_TREADY;
  assign out_last  = out_fire && (out_idx == nn - 1'b1);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (wr_hs && S_AXI_AWADDR[3:2] == 2'd0) begin
        if (S_AXI_WDATA == 32'd1)      state_nxt = LOAD_A;
        else if (S_AXI_WDATA == 32'd2) state_nxt = LOAD_B;
      end
      LOAD_A:  if (load_last) state_nxt = IDLE;
      LOAD_B:  if (load_last) state_nxt = CALC;
      CALC:    if (calc_last) state_nxt = OUT;
      OUT:     if (out_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    S_AXIS_TREADY = (state == LOAD_A) || (state == LOAD_B);
    M_AXIS_TVALID = (state == OUT);
    M_AXIS_TLAST  = (state == OUT) && (out_idx == nn - 1'b1);
    M_AXIS_TDATA  = (state == OUT) ? c_mem[out_idx[AW-1:0]] : 32'd0;
  end

  // One MAC per cycle: k innermost, then j, then i, so C is produced row-major.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ld_idx  <= '0;
      out_idx <= '0;
      ci      <= '0;
      cj      <= '0;
      ck      <= '0;
      acc     <= '0;
    end else begin
      if (load_fire) ld_idx <= load_last ? '0 : ld_idx + 1'b1;
      if (out_fire)  out_idx <= out_last ? '0 : out_idx + 1'b1;
      if (state == CALC) begin
        if (ck == n_m1) begin
          ck  <= '0;
          acc <= '0;
          if (cj == n_m1) begin
            cj <= '0;
            ci <= (ci == n_m1) ? '0 : ci + 1'b1;
          end else begin
            cj <= cj + 1'b1;
          end
        end else begin
          ck  <= ck + 1'b1;
          acc <= mac_sum;
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (load_fire && state == LOAD_A) a_mem[ld_idx[AW-1:0]] <= S_AXIS_TDATA;
    if (load_fire && state == LOAD_B) b_mem[ld_idx[AW-1:0]] <= S_AXIS_TDATA;
    if (state == CALC && ck == n_m1)  c_mem[c_addr[AW-1:0]] <= mac_sum;
  end

endmodule

// File: tb/tb_gemm_top.sv
// Randomized scoreboard bench for gemm_top: expected C words are queued from a
// plain-arithmetic matrix model and popped by an independent output monitor.
module tb_gemm_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata, s_tdata, m_tdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb, s_tstrb, m_tstrb;
  logic [1:0]  bresp, rresp;
  logic        s_tlast, s_tvalid, s_tready, m_tlast, m_tvalid, m_tready;

  always #5 clk = ~clk;

  gemm_top #(.MAX_N(8)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TLAST(m_tlast),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready)
  );

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] a_m [64];
  logic [31:0] b_m [64];
  int          checks = 0;
  int          failures = 0;
  logic        tready_level = 1'b1;
  logic        bp_random = 1'b0;
  logic        stalled = 1'b0;
  logic [31:0] held_data;
  logic        held_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  function automatic int eff_n(input logic [31:0] v);
    return (v[3:0] == 4'd0 || v[3:0] > 4'd8) ? 8 : int'(v[3:0]);
  endfunction

  // Reference model: textbook triple sum with 32-bit wraparound.
  task automatic push_expected(input int n);
    beat_t b;
    logic [31:0] sum;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        sum = 32'd0;
        for (int k = 0; k < n; k++) sum = sum + a_m[i*n+k] * b_m[k*n+j];
        b.data = sum;
        b.last = (i == n-1) && (j == n-1);
        exp_q.push_back(b);
      end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
    logic hs = 1'b0;
    int   t = 0;
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1; wstrb = 4'($urandom);
    while (!hs && t < 20) begin
      hs = awready && wready;
      @(posedge clk); #1; t++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!hs) fail_now("write_addr_accept");
    t = 0;
    while (!bvalid && t < 20) begin @(posedge clk); #1; t++; end
    check("write_bvalid", {31'd0, bvalid}, 32'd1);
    check("write_bresp", {30'd0, bresp}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
    logic hs = 1'b0;
    int   t = 0;
    araddr = addr; arvalid = 1'b1;
    while (!hs && t < 20) begin
      hs = arready;
      @(posedge clk); #1; t++;
    end
    arvalid = 1'b0;
    if (!hs) fail_now("read_addr_accept");
    t = 0;
    while (!rvalid && t < 20) begin @(posedge clk); #1; t++; end
    check("read_rvalid", {31'd0, rvalid}, 32'd1);
    data = rdata;
    @(posedge clk); #1;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(addr, d);
    check(name, d, exp);
  endtask

  // Words go out back-to-back; the DUT must keep TREADY up for the whole matrix.
  task automatic send_stream(input int cnt, input bit to_b);
    logic ok = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      s_tdata  = to_b ? b_m[i] : a_m[i];
      s_tvalid = 1'b1;
      s_tlast  = 1'($urandom);
      s_tstrb  = 4'($urandom);
      ok       = ok & s_tready;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    check("load_tready_held", {31'd0, ok}, 32'd1);
    check("tready_after_load", {31'd0, s_tready}, 32'd0);
  endtask

  task automatic wait_drain(input int limit);
    int t = 0;
    while (exp_q.size() != 0 && t < limit) begin @(posedge clk); #1; t++; end
    if (exp_q.size() != 0) begin
      fail_now("output_drain");
      exp_q.delete();
    end
  endtask

  task automatic run_b(input int n);
    axi_write(32'h0, 32'd2);
    push_expected(n);
    send_stream(n*n, 1'b1);
  endtask

  // Monitor: pops one expected beat per output handshake and checks stall stability.
  always @(negedge clk) begin
    if (rst_n && m_tvalid) begin
      if (stalled) begin
        check("stall_tdata_hold", m_tdata, held_data);
        check("stall_tlast_hold", {31'd0, m_tlast}, {31'd0, held_last});
      end
      if (m_tready) begin
        stalled = 1'b0;
        check("out_tstrb", {28'd0, m_tstrb}, 32'hF);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL unexpected_output: got 0x%08h expected none", m_tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("out_tdata", m_tdata, e.data);
          check("out_tlast", {31'd0, m_tlast}, {31'd0, e.last});
        end
      end else begin
        stalled   = 1'b1;
        held_data = m_tdata;
        held_last = m_tlast;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_tready = bp_random ? (($urandom % 4) != 0) : tready_level;
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    int t;
    logic [31:0] sz;
    rst_n = 1'b0;
    awaddr = '0; wdata = '0; awvalid = 1'b0; wvalid = 1'b0; wstrb = 4'hF; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    s_tdata = '0; s_tstrb = 4'hF; s_tlast = 1'b0; s_tvalid = 1'b0;

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_s_tready", {31'd0, s_tready}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
    check("rst_m_tdata", m_tdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("awready_after_rst", {31'd0, awready}, 32'd1);
    read_check("size_after_rst", 32'h4, 32'd8);
    read_check("mode_after_rst", 32'h0, 32'd0);
    read_check("reg_0c", 32'hC, 32'd0);

    // 2x2 directed product
    axi_write(32'h4, 32'd2);
    axi_write(32'h0, 32'd1);
    for (int i = 0; i < 4; i++) begin a_m[i] = 32'(i + 1); b_m[i] = 32'(i + 5); end
    send_stream(4, 1'b0);
    run_b(2);
    wait_drain(200);
    read_check("status_idle", 32'h8, 32'd0);

    // Identity A, two B runs reusing the same A load
    axi_write(32'h4, 32'd4);
    axi_write(32'h0, 32'd1);
    for (int i = 0; i < 16; i++) a_m[i] = (i % 5 == 0) ? 32'd1 : 32'd0;
    send_stream(16, 1'b0);
    for (int i = 0; i < 16; i++) b_m[i] = 32'(i);
    run_b(4);
    wait_drain(300);
    for (int i = 0; i < 16; i++) b_m[i] = 32'(15 - i);
    run_b(4);
    wait_drain(300);

    // 1x1 signed wraparound
    axi_write(32'h4, 32'd1);
    axi_write(32'h0, 32'd1);
    a_m[0] = 32'hFFFF_FFFD;
    b_m[0] = 32'h7FFF_FFFF;
    send_stream(1, 1'b0);
    run_b(1);
    wait_drain(50);

    // 8x8 random with a 3-cycle sink stall mid-stream
    axi_write(32'h4, 32'd8);
    axi_write(32'h0, 32'd1);
    for (int i = 0; i < 64; i++) begin a_m[i] = $urandom; b_m[i] = $urandom; end
    send_stream(64, 1'b0);
    run_b(8);
    t = 0;
    while (!m_tvalid && t < 700) begin @(posedge clk); #1; t++; end
    if (!m_tvalid) fail_now("first_output_8x8");
    repeat (10) @(negedge clk);
    tready_level = 1'b0;
    repeat (3) @(negedge clk);
    tready_level = 1'b1;
    wait_drain(300);

    // Random sizes (including out-of-range values) under random backpressure
    bp_random = 1'b1;
    for (int r = 0; r < 3; r++) begin
      sz = 32'($urandom_range(0, 15));
      n  = eff_n(sz);
      axi_write(32'h4, sz);
      read_check("size_readback", 32'h4, 32'(n));
      axi_write(32'h0, 32'd1);
      for (int i = 0; i < n*n; i++) a_m[i] = $urandom;
      send_stream(n*n, 1'b0);
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < n*n; i++) b_m[i] = $urandom;
        run_b(n);
        wait_drain(2000);
      end
    end
    bp_random = 1'b0;

    // Mode values other than 1 and 2 leave the block idle
    axi_write(32'h0, 32'd3);
    read_check("status_bad_mode", 32'h8, 32'd0);

    // SIZE write while computing is acknowledged but ignored
    axi_write(32'h4, 32'd4);
    axi_write(32'h0, 32'd1);
    for (int i = 0; i < 16; i++) begin a_m[i] = $urandom; b_m[i] = $urandom; end
    send_stream(16, 1'b0);
    run_b(4);
    axi_write(32'h4, 32'd3);
    read_check("status_calc_busy", 32'h8, 32'h7);
    wait_drain(300);
    read_check("size_unchanged", 32'h4, 32'd4);

    // Reset while the result stream is stalled
    tready_level = 1'b0;
    axi_write(32'h0, 32'd2);
    send_stream(16, 1'b1);
    t = 0;
    while (!m_tvalid && t < 200) begin @(posedge clk); #1; t++; end
    if (!m_tvalid) fail_now("enter_out_state");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_out_tlast", {31'd0, m_tlast}, 32'd0);
    check("rst_out_tdata", m_tdata, 32'd0);
    check("rst_out_awready", {31'd0, awready}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tready_level = 1'b1;
    @(posedge clk); #1;
    read_check("status_after_midrst", 32'h8, 32'd0);
    read_check("size_after_midrst", 32'h4, 32'd8);
    repeat (5) @(posedge clk);
    check("no_tvalid_after_midrst", {31'd0, m_tvalid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gemm_top.md
GEMM_TOP -- requirements
Module: gemm_top

Interface
REQ-001 Parameter MAX_N, default 8: maximum square matrix dimension; buffers hold MAX_N*MAX_N 32-bit words.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 S_AXI_ACLK  in  1  sole clock; all logic is rising-edge.
REQ-004 S_AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-005 S_AXI_AWADDR in 32, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: AXI-Lite write address.
REQ-006 S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: AXI-Lite write data.
REQ-007 S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: AXI-Lite write response.
REQ-008 S_AXI_ARADDR in 32, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: AXI-Lite read address.
REQ-009 S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: AXI-Lite read data.
REQ-010 S_AXIS_TDATA in 32, S_AXIS_TSTRB in 4, S_AXIS_TLAST in 1, S_AXIS_TVALID in 1, S_AXIS_TREADY out 1: input matrix stream.
REQ-011 M_AXIS_TDATA out 32, M_AXIS_TSTRB out 4, M_AXIS_TLAST out 1, M_AXIS_TVALID out 1, M_AXIS_TREADY in 1: result stream.

Function
REQ-012 Register map decoded on address bits [3:2]: 0x00 MODE (W/R), 0x04 SIZE N (W/R, bits [3:0]), 0x08 STATUS (R: bit0 busy = state not IDLE, bits [3:1] state code), 0x0C reads 0.
REQ-013 AWREADY and WREADY are 1 whenever BVALID is 0; write completes when AWVALID and WVALID are both high in the same cycle; WSTRB ignored (full-word writes).
REQ-014 BVALID rises the cycle after a write handshake with BRESP=0, clears on BREADY.
REQ-015 ARREADY is 1 when RVALID is 0; RVALID rises the cycle after ARVALID with RDATA of the addressed register, RRESP=0, clears on RREADY.
REQ-016 SIZE values 0 or above MAX_N are treated as MAX_N; SIZE and MODE writes outside IDLE are ignored but still acknowledged.
REQ-017 States: IDLE, LOAD_A, LOAD_B, CALC, OUT (codes 0..4).
REQ-018 IDLE: MODE write value 1 -> LOAD_A; value 2 -> LOAD_B; other values no effect.
REQ-019 LOAD_A/LOAD_B: S_AXIS_TREADY=1; every cycle with TVALID high stores one word row-major into buffer A/B; after N*N words LOAD_A -> IDLE, LOAD_B -> CALC; TLAST and TSTRB ignored; TREADY=0 in all other states.
REQ-020 Input words accepted back-to-back at one per cycle without stalls.
REQ-021 CALC: C[i][j] = sum over k of A[i][k]*B[k][j], 32-bit two's-complement signed operands, products and sum truncated to low 32 bits; result stored to buffer C; one MAC per cycle permitted.
REQ-022 CALC -> OUT when all N*N results are ready; first M_AXIS_TVALID no later than N*N*N+4 cycles after the last B word.
REQ-023 OUT: C streamed row-major, TVALID held high continuously until the last word; word advances only on TVALID&TREADY; TDATA stable while TREADY low.
REQ-024 M_AXIS_TLAST=1 with the N*N-th word only; M_AXIS_TSTRB=4'hF constant.
REQ-025 After final output handshake -> IDLE; buffer A retained so multiple B runs reuse one A load.

Reset
REQ-026 Reset (asynchronous, any time incl. mid-transfer): state IDLE, SIZE=MAX_N, MODE=0, all VALID/READY outputs except AWREADY/WREADY/ARREADY low, TLAST=0, TDATA/RDATA=0, counters 0; AWREADY/WREADY/ARREADY low during reset, high the cycle after release; buffer contents need not be cleared.

Verification
REQ-027 Reset held 10 cycles -> TVALIDs, BVALID, RVALID, S_AXIS_TREADY all 0; read 0x04 after release returns 8.
REQ-028 SIZE=2, MODE=1, send A=1,2,3,4; MODE=2, send B=5,6,7,8 -> output 19,22,43,50, TLAST on 50, then STATUS=0.
REQ-029 SIZE=4, A=identity, B=0..15 -> output 0..15 contiguous, TLAST on 15; second run B=15..0 without reloading A -> 15..0.
REQ-030 SIZE=1, A=0xFFFFFFFD (-3), B=0x7FFFFFFF -> single output 0x80000003 with TLAST=1.
REQ-031 SIZE=8 full run with M_AXIS_TREADY low 3 cycles mid-stream -> 64 words, none lost or duplicated, TDATA held during stall.
REQ-032 Write SIZE=3 during CALC -> ignored, BVALID still returned; STATUS busy=1; reset asserted during OUT -> IDLE, TVALID 0 immediately.
